frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer_pkg.sv | 15 +
 rtl/frame_sequencer_pixel_prefetch_fifo.sv | 46 ++++
 rtl/frame_sequencer.sv | 115 +++++++++++
 tb/tb_frame_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared video pipeline constants and the frame sequencer state encoding,
// used by the LCD timing, video output and framebuffer sequencing blocks.
package frame_sequencer_pkg;

  localparam int VID_X_PX   = 800;
  localparam int VID_Y_PX   = 480;
  localparam int VID_ADDR_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_pixel_prefetch_fifo.sv
// Two-entry pixel prefetch buffer between framebuffer reads and the video
// output; head reads as zero while empty.
module frame_sequencer_pixel_prefetch_fifo (
  input  logic       LCDCLK,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [1:0] occupancy
);

  logic [7:0] mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count_reg != 2'd0);
    do_push = push && ((count_reg != 2'd2) || do_pop);
  end

  always_ff @(posedge LCDCLK) begin
    if (reset || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge LCDCLK) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head      = (count_reg != 2'd0) ? mem_reg[rd_ptr_reg] : 8'h00;
  assign occupancy = count_reg;

endmodule

// File: rtl/frame_sequencer.sv
// Double-buffered framebuffer read sequencer: walks the front bank pixel by
// pixel into a 2-entry prefetch buffer and swaps banks only at frame wrap.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int X_PX   = VID_X_PX,
  parameter int Y_PX   = VID_Y_PX,
  parameter int ADDR_W = VID_ADDR_W
) (
  input  logic              LCDCLK,
  input  logic              i_Reset,
  input  logic              i_Enable,
  input  logic              i_Swap_Request,
  input  logic              i_Pixel_Ack,
  input  logic [7:0]        i_Rd_Data,
  output logic              o_Rd_En,
  output logic [ADDR_W:0]   o_Rd_Addr,
  output logic [7:0]        o_Pixel_Data,
  output logic              o_Begin,
  output logic              o_Disable,
  output logic              o_Front_Bank,
  output logic              o_Swap_Done,
  output logic              o_Underrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(X_PX * Y_PX - 1);

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] index_reg;
  logic              bank_reg;
  logic              pending_reg;
  logic              inflight_reg;
  logic              swap_done_reg;
  logic              underrun_reg;

  logic [1:0]        occupancy;
  logic [7:0]        head;
  logic              active, pop, push, flush, rd_en, wrap_swap;
  logic [2:0]        level, occ_next;

  always_comb begin
    active    = (state_reg != ST_IDLE);
    pop       = active && i_Pixel_Ack && (occupancy != 2'd0);
    flush     = active && !i_Enable;
    push      = inflight_reg;
    // Buffered plus in-flight pixels, net of this cycle's pop, never exceed 2.
    level     = {1'b0, occupancy} + {2'b00, inflight_reg} - {2'b00, pop};
    occ_next  = {1'b0, occupancy} + {2'b00, push} - {2'b00, pop};
    rd_en     = active && !i_Reset && (level < 3'd2);
    wrap_swap = rd_en && (index_reg == LAST_IDX) && (pending_reg || i_Swap_Request);

    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_Enable) state_next = ST_PRIME;
      ST_PRIME: begin
        if (!i_Enable)              state_next = ST_IDLE;
        else if (occ_next == 3'd2)  state_next = ST_RUN;
      end
      ST_RUN:   if (!i_Enable) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge LCDCLK) begin
    if (i_Reset) begin
      state_reg     <= ST_IDLE;
      index_reg     <= '0;
      bank_reg      <= 1'b0;
      pending_reg   <= 1'b0;
      inflight_reg  <= 1'b0;
      swap_done_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      swap_done_reg <= wrap_swap;
      if (active && i_Pixel_Ack && (occupancy == 2'd0)) underrun_reg <= 1'b1;

      if (wrap_swap) begin
        bank_reg    <= ~bank_reg;
        pending_reg <= 1'b0;
      end else if (i_Swap_Request) begin
        pending_reg <= 1'b1;
      end

      if (flush) begin
        index_reg    <= '0;
        inflight_reg <= 1'b0;
      end else begin
        inflight_reg <= rd_en;
        if (rd_en) index_reg <= (index_reg == LAST_IDX) ? '0 : index_reg + ADDR_W'(1);
      end
    end
  end

  frame_sequencer_pixel_prefetch_fifo u_prefetch (
    .LCDCLK    (LCDCLK),
    .reset     (i_Reset),
    .flush     (flush),
    .push      (push),
    .push_data (i_Rd_Data),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy)
  );

  assign o_Rd_En      = rd_en;
  assign o_Rd_Addr    = {bank_reg, index_reg};
  assign o_Pixel_Data = head;
  assign o_Begin      = (state_reg == ST_RUN);
  assign o_Disable    = (state_reg == ST_IDLE);
  assign o_Front_Bank = bank_reg;
  assign o_Swap_Done  = swap_done_reg;
  assign o_Underrun   = underrun_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer on a reduced 20x16 frame: a RAM model
// returns index[7:0], expected pixels are queued per ack and checked on output.
module tb_frame_sequencer;

  localparam int X_PX   = 20;
  localparam int Y_PX   = 16;
  localparam int ADDR_W = 9;
  localparam int N      = X_PX * Y_PX;

  logic              LCDCLK = 1'b0;
  logic              i_Reset, i_Enable, i_Swap_Request, i_Pixel_Ack;
  logic [7:0]        i_Rd_Data = 8'h00;
  logic              o_Rd_En;
  logic [ADDR_W:0]   o_Rd_Addr;
  logic [7:0]        o_Pixel_Data;
  logic              o_Begin, o_Disable, o_Front_Bank, o_Swap_Done, o_Underrun;

  always #5 LCDCLK = ~LCDCLK;

  frame_sequencer #(.X_PX(X_PX), .Y_PX(Y_PX), .ADDR_W(ADDR_W)) dut (
    .LCDCLK         (LCDCLK),
    .i_Reset        (i_Reset),
    .i_Enable       (i_Enable),
    .i_Swap_Request (i_Swap_Request),
    .i_Pixel_Ack    (i_Pixel_Ack),
    .i_Rd_Data      (i_Rd_Data),
    .o_Rd_En        (o_Rd_En),
    .o_Rd_Addr      (o_Rd_Addr),
    .o_Pixel_Data   (o_Pixel_Data),
    .o_Begin        (o_Begin),
    .o_Disable      (o_Disable),
    .o_Front_Bank   (o_Front_Bank),
    .o_Swap_Done    (o_Swap_Done),
    .o_Underrun     (o_Underrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge LCDCLK);
    #1;
  endtask

  // RAM model: data for a read strobed in cycle k is presented during cycle k+1.
  logic            ram_req = 1'b0;
  logic [ADDR_W:0] ram_addr = '0;
  always @(negedge LCDCLK) begin
    ram_req  = o_Rd_En;
    ram_addr = o_Rd_Addr;
  end
  always @(posedge LCDCLK) begin
    #1;
    i_Rd_Data = ram_req ? ram_addr[7:0] : 8'hA5;
  end

  // Scoreboard and read-address reference
  logic [7:0] exp_pix_q [$];
  int   exp_rd_idx = 0;
  logic exp_bank = 1'b0, exp_pend = 1'b0, exp_sd = 1'b0;
  int   sd_count = 0, zero_reads = 0;
  logic last_wrap_bank = 1'b0;

  always @(negedge LCDCLK) begin
    logic       fire;
    logic [7:0] exp_pix;
    if (i_Reset) begin
      exp_rd_idx = 0; exp_bank = 1'b0; exp_pend = 1'b0; exp_sd = 1'b0;
    end else begin
      check_eq("front_bank", o_Front_Bank, exp_bank);
      check_eq("swap_done", o_Swap_Done, exp_sd);
      if (o_Swap_Done) sd_count++;
      if (o_Disable) exp_rd_idx = 0;
      fire = 1'b0;
      if (o_Rd_En) begin
        check_eq("rd_addr", o_Rd_Addr, {exp_bank, ADDR_W'(exp_rd_idx)});
        if (exp_rd_idx == 0) begin
          zero_reads++;
          last_wrap_bank = o_Rd_Addr[ADDR_W];
        end
        if (exp_rd_idx == N - 1) begin
          fire = exp_pend || i_Swap_Request;
          exp_rd_idx = 0;
        end else begin
          exp_rd_idx++;
        end
      end
      if (fire) begin
        exp_bank = ~exp_bank;
        exp_pend = 1'b0;
      end else if (i_Swap_Request) begin
        exp_pend = 1'b1;
      end
      exp_sd = fire;
      if (i_Pixel_Ack && o_Begin) begin
        check_eq("sb_nonempty", exp_pix_q.size() != 0, 1);
        if (exp_pix_q.size() != 0) begin
          exp_pix = exp_pix_q.pop_front();
          check_eq("pixel_data", o_Pixel_Data, exp_pix);
        end
      end
    end
  end

  int pix_idx = 0;

  task automatic ack_cycle();
    i_Pixel_Ack = 1'b1;
    exp_pix_q.push_back(8'(pix_idx));
    pix_idx = (pix_idx + 1) % N;
  endtask

  task automatic wait_run(input string tag, output int prime_cycles);
    int waited;
    prime_cycles = 0;
    waited = 0;
    do begin
      @(negedge LCDCLK);
      if (!o_Disable && !o_Begin) prime_cycles++;
      waited++;
    end while (!o_Begin && waited < 20);
    check_eq(tag, o_Begin, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   prime_cycles, z0, sd0;
    logic hit;
    i_Reset = 1'b1; i_Enable = 1'b0; i_Swap_Request = 1'b0; i_Pixel_Ack = 1'b0;
    repeat (3) tick();
    i_Reset = 1'b0;
    tick();
    check_eq("rst_rd_en", o_Rd_En, 1'b0);
    check_eq("rst_rd_addr", o_Rd_Addr, 0);
    check_eq("rst_pixel", o_Pixel_Data, 8'h00);
    check_eq("rst_begin", o_Begin, 1'b0);
    check_eq("rst_disable", o_Disable, 1'b1);
    check_eq("rst_bank", o_Front_Bank, 1'b0);
    check_eq("rst_swap_done", o_Swap_Done, 1'b0);
    check_eq("rst_underrun", o_Underrun, 1'b0);
    $display("txn reset: idle outputs checked");

    // Startup: two priming reads, RUN once two pixels are buffered
    z0 = zero_reads;
    i_Enable = 1'b1;
    wait_run("startup_run", prime_cycles);
    check_eq("prime_cycles", prime_cycles, 3);
    check_eq("startup_pixel", o_Pixel_Data, 8'h00);
    tick();
    $display("txn startup: prime_cycles=%0d", prime_cycles);

    // Continuous ack over two frames
    for (int i = 0; i < 2 * N; i++) begin
      ack_cycle();
      tick();
    end
    i_Pixel_Ack = 1'b0;
    check_eq("stream_underrun", o_Underrun, 1'b0);
    check_eq("stream_wraps", zero_reads - z0, 3);
    $display("txn stream: %0d pixels acked", 2 * N);

    // Mid-frame swap request, second request before wrap ignored
    sd0 = sd_count;
    for (int i = 0; i < N + 10; i++) begin
      i_Swap_Request = (i == 50) || (i == 100);
      ack_cycle();
      tick();
    end
    i_Swap_Request = 1'b0;
    i_Pixel_Ack = 1'b0;
    check_eq("swap_bank", o_Front_Bank, 1'b1);
    check_eq("swap_pulses", sd_count - sd0, 1);
    check_eq("swap_wrap_addr_bank", last_wrap_bank, 1'b1);
    $display("txn swap_mid: front_bank=%0d", o_Front_Bank);

    // Swap request coinciding with the last-index read
    sd0 = sd_count;
    hit = 1'b0;
    for (int i = 0; i < N + 20; i++) begin
      ack_cycle();
      #1;
      i_Swap_Request = !hit && o_Rd_En && (o_Rd_Addr[ADDR_W-1:0] == ADDR_W'(N - 1));
      if (i_Swap_Request) hit = 1'b1;
      tick();
      i_Swap_Request = 1'b0;
    end
    i_Pixel_Ack = 1'b0;
    check_eq("swap_last_hit", hit, 1'b1);
    check_eq("swap_last_bank", o_Front_Bank, 1'b0);
    check_eq("swap_last_pulses", sd_count - sd0, 1);
    check_eq("swap_last_wrap_bank", last_wrap_bank, 1'b0);
    $display("txn swap_at_wrap: front_bank=%0d", o_Front_Bank);

    // Disable mid-frame at index 100, then restart
    hit = 1'b0;
    for (int i = 0; i < 2 * N && !hit; i++) begin
      ack_cycle();
      #1;
      if (o_Rd_En && (o_Rd_Addr[ADDR_W-1:0] == ADDR_W'(100))) hit = 1'b1;
      tick();
    end
    check_eq("disable_index_seen", hit, 1'b1);
    i_Pixel_Ack = 1'b0;
    i_Enable = 1'b0;
    tick();
    check_eq("disable_idle", o_Disable, 1'b1);
    check_eq("disable_begin", o_Begin, 1'b0);
    check_eq("disable_flushed", o_Pixel_Data, 8'h00);
    check_eq("disable_rd_en", o_Rd_En, 1'b0);
    i_Pixel_Ack = 1'b1;
    repeat (2) tick();
    i_Pixel_Ack = 1'b0;
    check_eq("idle_ack_underrun", o_Underrun, 1'b0);
    check_eq("idle_sb_empty", exp_pix_q.size(), 0);
    pix_idx = 0;
    i_Enable = 1'b1;
    wait_run("restart_run", prime_cycles);
    check_eq("restart_pixel", o_Pixel_Data, 8'h00);
    check_eq("restart_bank", o_Front_Bank, 1'b0);
    tick();
    $display("txn restart: resumed at index 0 bank %0d", o_Front_Bank);

    // Underrun: ack while the buffer is still empty during priming
    i_Enable = 1'b0;
    tick();
    i_Enable = 1'b1;
    i_Pixel_Ack = 1'b1;
    tick();
    check_eq("underrun_pixel", o_Pixel_Data, 8'h00);
    tick();
    i_Pixel_Ack = 1'b0;
    check_eq("underrun_set", o_Underrun, 1'b1);
    wait_run("underrun_run", prime_cycles);
    pix_idx = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      ack_cycle();
      tick();
    end
    i_Pixel_Ack = 1'b0;
    check_eq("underrun_sticky_run", o_Underrun, 1'b1);
    i_Enable = 1'b0;
    tick();
    check_eq("underrun_sticky_idle", o_Underrun, 1'b1);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    tick();
    check_eq("underrun_cleared", o_Underrun, 1'b0);
    check_eq("final_sb_empty", exp_pix_q.size(), 0);
    $display("txn underrun: flag set, held, cleared by reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
